// File: rtl/dds_cfg_pkg.sv
// rtl/dds_cfg_pkg.sv - shared widths, step table and state encodings for the DDS config master
package dds_cfg_pkg;

    localparam int PHASE_W = 32;

    // Steps for 1 Hz, 10 Hz, 1 kHz and 100 kHz at a 50 MHz DDS clock
    localparam logic [31:0] STEP_TABLE [4] = '{32'd86, 32'd859, 32'd85899, 32'd8589935};

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

endpackage

// File: rtl/dds_step_sat.sv
// rtl/dds_step_sat.sv - combinational saturating add/sub of a step to the tuning word
module dds_step_sat #(
    parameter int W = 32
) (
    input  logic [W-1:0] word,
    input  logic [W-1:0] step,
    input  logic         dir,
    input  logic [W-1:0] min_word,
    input  logic [W-1:0] max_word,
    output logic [W-1:0] next_word,
    output logic         clipped,
    output logic         changed
);

    // One extra bit so neither the sum nor the lower-bound threshold can wrap
    logic [W:0] sum;
    logic [W:0] floor_thr;

    assign sum       = {1'b0, word} + {1'b0, step};
    assign floor_thr = {1'b0, min_word} + {1'b0, step};

    always_comb begin
        next_word = word;
        clipped   = 1'b0;
        if (dir) begin
            if (sum > {1'b0, max_word}) begin
                next_word = max_word;
                clipped   = 1'b1;
            end else begin
                next_word = sum[W-1:0];
            end
        end else begin
            if ({1'b0, word} < floor_thr) begin
                next_word = min_word;
                clipped   = 1'b1;
            end else begin
                next_word = word - step;
            end
        end
    end

    assign changed = (next_word != word);

endmodule

// File: rtl/dds_freq_cfg_master.sv
// rtl/dds_freq_cfg_master.sv - owns the DDS tuning word and streams it to the DDS config channel
module dds_freq_cfg_master #(
    parameter int                 PHASE_W   = dds_cfg_pkg::PHASE_W,
    parameter logic [PHASE_W-1:0] INIT_WORD = 32'd85899,
    parameter logic [PHASE_W-1:0] MIN_WORD  = 32'd1,
    parameter logic [PHASE_W-1:0] MAX_WORD  = 32'h7FFF_FFFF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               freq_up_trigger_i,
    input  logic               freq_down_trigger_i,
    input  logic [1:0]         step_sel_i,
    input  logic               m_axis_config_tready,
    output logic               m_axis_config_tvalid,
    output logic [PHASE_W-1:0] m_axis_config_tdata,
    output logic [PHASE_W-1:0] freq_word_o,
    output logic               cfg_busy_o,
    output logic               sat_o
);

    import dds_cfg_pkg::*;

    logic [1:0]         state;
    logic               pending;
    logic [PHASE_W-1:0] freq_word;
    logic [PHASE_W-1:0] tdata;
    logic               sat;

    logic [PHASE_W-1:0] step;
    logic [PHASE_W-1:0] next_word;
    logic               clipped;
    logic               changed;
    logic               trig;
    logic               eff;

    assign step = PHASE_W'(STEP_TABLE[step_sel_i]);
    assign trig = freq_up_trigger_i ^ freq_down_trigger_i;
    assign eff  = trig & changed;

    dds_step_sat #(.W(PHASE_W)) u_step_sat (
        .word      (freq_word),
        .step      (step),
        .dir       (freq_up_trigger_i),
        .min_word  (MIN_WORD),
        .max_word  (MAX_WORD),
        .next_word (next_word),
        .clipped   (clipped),
        .changed   (changed)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_INIT;
            pending   <= 1'b0;
            freq_word <= INIT_WORD;
            tdata     <= INIT_WORD;
            sat       <= 1'b0;
        end else begin
            sat <= trig & clipped;
            if (trig) begin
                freq_word <= next_word;
            end
            case (state)
                ST_INIT: begin
                    state <= ST_SEND;
                    tdata <= eff ? next_word : freq_word;
                end
                ST_IDLE: begin
                    if (eff) begin
                        state <= ST_SEND;
                        tdata <= next_word;
                    end
                end
                ST_SEND: begin
                    // A change arriving on the handshake cycle is folded straight into the reload
                    if (m_axis_config_tready) begin
                        if (pending || eff) begin
                            tdata   <= eff ? next_word : freq_word;
                            pending <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (eff) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign m_axis_config_tvalid = (state == ST_SEND);
    assign m_axis_config_tdata  = tdata;
    assign freq_word_o          = freq_word;
    assign cfg_busy_o           = (state != ST_IDLE) | pending;
    assign sat_o                = sat;

endmodule
